// File: rtl/pulpino_boot_pkg.sv
// Package: pulpino_boot_pkg
// Shared definitions for the PULPino boot sequencer.
//  - boot_state_e : 3-bit FSM state encoding. It is also driven onto the LEDs.
//  - DEF_*        : default cycle counts for a 50 MHz board clock.
//  - TRIPS_MAX    : saturation value of the watchdog trip counter.
//  - max3         : helper used to size the shared phase counter.
package pulpino_boot_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SYS_HOLD  = 3'd1,
        S_CORE_HOLD = 3'd2,
        S_FETCH_DLY = 3'd3,
        S_RUN       = 3'd4,
        S_HALT      = 3'd5,
        S_WDT_TRIP  = 3'd6
    } boot_state_e;

    localparam int unsigned DEF_DEBOUNCE_CYC  = 32'd1_000_000;
    localparam int unsigned DEF_SYS_HOLD_CYC  = 32'd16;
    localparam int unsigned DEF_CORE_HOLD_CYC = 32'd8;
    localparam int unsigned DEF_FETCH_DLY_CYC = 32'd4;
    localparam int unsigned DEF_WDT_CYC       = 32'd65_536;

    localparam logic [3:0] TRIPS_MAX = 4'd15;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pulpino_debounce.sv
// Module: pulpino_debounce
// This module conditions the raw KEY[0] push-button.
// The button is asynchronous and active-low. A 2-FF synchroniser brings it into the clock domain.
// A run-length counter then accepts a new level only after DEBOUNCE_CYC consecutive samples
// that differ from the currently accepted level.
// Ports:
//  clk       in  1  system clock
//  reset_n   in  1  synchronous active-low reset (accepted level = released)
//  btn_n     in  1  raw button, active-low, asynchronous
//  btn_press out 1  registered single-cycle pulse when the accepted level goes 1->0
module pulpino_debounce
    import pulpino_boot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic btn_press
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;
    logic             differ_s;
    logic             flip_s;

    // A flip happens on the DEBOUNCE_CYC-th consecutive differing sample.
    always_comb begin
        differ_s = (sync2_r != level_r);
        flip_s   = differ_s && (cnt_r == CNT_LAST);
    end

    // Synchroniser, run-length counter, accepted level and press pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            level_r <= 1'b1;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (!differ_s) begin
                cnt_r <= '0;
            end else if (flip_s) begin
                cnt_r   <= '0;
                level_r <= sync2_r;
                // The old level was 1, so the level is now falling: this is a press.
                press_r <= level_r;
            end else begin
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign btn_press = press_r;

endmodule

// File: rtl/pulpino_boot_sequencer.sv
// Module: pulpino_boot_sequencer
// This module sequences the bring-up of the PULPino/Qsys system.
// It releases the Qsys fabric reset, then the core reset, then fetch_enable.
// It then supervises the running core with an optional heartbeat watchdog.
// A debounced button press restarts the sequence from any state other than IDLE.
// Every output pin is registered and decoded from the next state, so the pins move on the same
// edge as the state change.
// Ports:
//  clk50        in  1  50 MHz system clock
//  reset_n      in  1  synchronous active-low reset
//  btn_n        in  1  raw push-button, active-low, asynchronous
//  wdt_en       in  1  watchdog enable, sampled each cycle
//  core_hb      in  1  core heartbeat; any edge counts as alive
//  core_eoc     in  1  core end-of-computation level
//  sys_rst_n    out 1  Qsys fabric reset, active-low
//  core_rst_n   out 1  core reset, active-low
//  fetch_enable out 1  core fetch enable
//  state_o      out 3  encoded FSM state
//  wdt_trips_o  out 4  saturating count of watchdog restarts
module pulpino_boot_sequencer
    import pulpino_boot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int unsigned SYS_HOLD_CYC  = DEF_SYS_HOLD_CYC,
    parameter int unsigned CORE_HOLD_CYC = DEF_CORE_HOLD_CYC,
    parameter int unsigned FETCH_DLY_CYC = DEF_FETCH_DLY_CYC,
    parameter int unsigned WDT_CYC       = DEF_WDT_CYC
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       wdt_en,
    input  logic       core_hb,
    input  logic       core_eoc,
    output logic       sys_rst_n,
    output logic       core_rst_n,
    output logic       fetch_enable,
    output logic [2:0] state_o,
    output logic [3:0] wdt_trips_o
);

    // One phase counter serves all three hold phases, so it is sized for the longest one.
    localparam int unsigned        PH_MAX     = max3(SYS_HOLD_CYC, CORE_HOLD_CYC, FETCH_DLY_CYC);
    localparam int unsigned        PH_W       = $clog2(PH_MAX + 1);
    localparam int unsigned        WDT_W      = $clog2(WDT_CYC + 1);
    localparam logic [PH_W-1:0]    SYS_LAST   = PH_W'(SYS_HOLD_CYC - 1);
    localparam logic [PH_W-1:0]    CORE_LAST  = PH_W'(CORE_HOLD_CYC - 1);
    localparam logic [PH_W-1:0]    FETCH_LAST = PH_W'(FETCH_DLY_CYC - 1);
    localparam logic [WDT_W-1:0]   WDT_LAST   = WDT_W'(WDT_CYC - 1);

    boot_state_e       state_r;
    boot_state_e       state_next_s;
    logic [PH_W-1:0]   phase_cnt_r;
    logic [PH_W-1:0]   phase_cnt_next_s;
    logic [WDT_W-1:0]  wdt_cnt_r;
    logic [WDT_W-1:0]  wdt_cnt_next_s;
    logic [3:0]        trips_r;
    logic [3:0]        trips_next_s;
    logic              hb_sync1_r;
    logic              hb_sync2_r;
    logic              hb_prev_r;
    logic              hb_edge_s;
    logic              btn_press_s;
    logic              phase_done_s;
    logic              wdt_term_s;
    logic              sys_rst_n_r;
    logic              core_rst_n_r;
    logic              fetch_enable_r;
    logic              sys_next_s;
    logic              core_next_s;
    logic              fetch_next_s;

    pulpino_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk       (clk50),
        .reset_n   (reset_n),
        .btn_n     (btn_n),
        .btn_press (btn_press_s)
    );

    // Phase timing, watchdog terminal count and next-state selection.
    always_comb begin
        hb_edge_s    = hb_sync2_r ^ hb_prev_r;
        phase_done_s = 1'b0;
        case (state_r)
            S_SYS_HOLD:  phase_done_s = (phase_cnt_r == SYS_LAST);
            S_CORE_HOLD: phase_done_s = (phase_cnt_r == CORE_LAST);
            S_FETCH_DLY: phase_done_s = (phase_cnt_r == FETCH_LAST);
            default:     phase_done_s = 1'b0;
        endcase
        // A heartbeat edge in the terminal cycle wins, and no trip occurs.
        wdt_term_s = wdt_en && (wdt_cnt_r == WDT_LAST) && !hb_edge_s;

        state_next_s = state_r;
        if (btn_press_s && (state_r != S_IDLE)) begin
            state_next_s = S_SYS_HOLD;
        end else begin
            case (state_r)
                S_IDLE:      state_next_s = S_SYS_HOLD;
                S_SYS_HOLD:  state_next_s = phase_done_s ? S_CORE_HOLD : S_SYS_HOLD;
                S_CORE_HOLD: state_next_s = phase_done_s ? S_FETCH_DLY : S_CORE_HOLD;
                S_FETCH_DLY: state_next_s = phase_done_s ? S_RUN : S_FETCH_DLY;
                S_RUN: begin
                    if (core_eoc) begin
                        state_next_s = S_HALT;
                    end else if (wdt_term_s) begin
                        state_next_s = S_WDT_TRIP;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end
                S_HALT:      state_next_s = S_HALT;
                S_WDT_TRIP:  state_next_s = S_SYS_HOLD;
                default:     state_next_s = S_IDLE;
            endcase
        end
    end

    // Counter updates and pin decode from the next state.
    always_comb begin
        // A press restarts the phase even when the state itself does not change (SYS_HOLD).
        if ((state_next_s != state_r) || btn_press_s) begin
            phase_cnt_next_s = '0;
        end else if ((state_r == S_SYS_HOLD) || (state_r == S_CORE_HOLD) ||
                     (state_r == S_FETCH_DLY)) begin
            phase_cnt_next_s = phase_cnt_r + 1'b1;
        end else begin
            phase_cnt_next_s = phase_cnt_r;
        end

        if ((state_next_s == S_RUN) && (state_r != S_RUN)) begin
            wdt_cnt_next_s = '0;
        end else if (hb_edge_s) begin
            wdt_cnt_next_s = '0;
        end else if ((state_r == S_RUN) && wdt_en && (wdt_cnt_r != WDT_LAST)) begin
            wdt_cnt_next_s = wdt_cnt_r + 1'b1;
        end else begin
            wdt_cnt_next_s = wdt_cnt_r;
        end

        if ((state_next_s == S_WDT_TRIP) && (trips_r != TRIPS_MAX)) begin
            trips_next_s = trips_r + 4'd1;
        end else begin
            trips_next_s = trips_r;
        end

        sys_next_s   = 1'b0;
        core_next_s  = 1'b0;
        fetch_next_s = 1'b0;
        case (state_next_s)
            S_CORE_HOLD: sys_next_s = 1'b1;
            S_FETCH_DLY: begin
                sys_next_s  = 1'b1;
                core_next_s = 1'b1;
            end
            S_RUN: begin
                sys_next_s   = 1'b1;
                core_next_s  = 1'b1;
                fetch_next_s = 1'b1;
            end
            S_HALT: begin
                sys_next_s  = 1'b1;
                core_next_s = 1'b1;
            end
            default: begin
                sys_next_s   = 1'b0;
                core_next_s  = 1'b0;
                fetch_next_s = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Counters, heartbeat synchroniser/edge detector and registered pin drivers.
    always_ff @(posedge clk50) begin
        if (!reset_n) begin
            phase_cnt_r    <= '0;
            wdt_cnt_r      <= '0;
            trips_r        <= 4'd0;
            hb_sync1_r     <= 1'b0;
            hb_sync2_r     <= 1'b0;
            hb_prev_r      <= 1'b0;
            sys_rst_n_r    <= 1'b0;
            core_rst_n_r   <= 1'b0;
            fetch_enable_r <= 1'b0;
        end else begin
            phase_cnt_r    <= phase_cnt_next_s;
            wdt_cnt_r      <= wdt_cnt_next_s;
            trips_r        <= trips_next_s;
            hb_sync1_r     <= core_hb;
            hb_sync2_r     <= hb_sync1_r;
            hb_prev_r      <= hb_sync2_r;
            sys_rst_n_r    <= sys_next_s;
            core_rst_n_r   <= core_next_s;
            fetch_enable_r <= fetch_next_s;
        end
    end

    assign sys_rst_n    = sys_rst_n_r;
    assign core_rst_n   = core_rst_n_r;
    assign fetch_enable = fetch_enable_r;
    assign state_o      = state_r;
    assign wdt_trips_o  = trips_r;

endmodule

// File: tb/tb_pulpino_boot_sequencer.sv
// Testbench for pulpino_boot_sequencer.
// The stimulus process predicts every change of the output vector from the sequencing rules.
// Each change is described by its state, trip count and the cycle it must appear in, and the
// prediction is pushed into a queue. A separate monitor pops the queue on each observed output
// change and compares the state, the pins, the trip count and the cycle.
module tb_pulpino_boot_sequencer;

    localparam int unsigned DB = 4;
    localparam int unsigned SH = 16;
    localparam int unsigned CH = 8;
    localparam int unsigned FD = 4;
    localparam int unsigned WD = 32;
    // Two synchroniser stages, then the debounce run of DB samples, then a registered press pulse.
    localparam int unsigned PRESS_LAT = DB + 3;
    // Two synchroniser stages, then the edge detector.
    localparam int unsigned HB_LAT = 3;

    localparam int ST_IDLE = 0, ST_SYS = 1, ST_CORE = 2, ST_FETCH = 3,
                   ST_RUN = 4, ST_HALT = 5, ST_TRIP = 6;

    typedef struct {
        int          st;
        int          trips;
        int unsigned cyc;
    } exp_t;

    logic       clk50 = 1'b0;
    logic       reset_n;
    logic       btn_n;
    logic       wdt_en;
    logic       core_hb;
    logic       core_eoc;
    logic       sys_rst_n;
    logic       core_rst_n;
    logic       fetch_enable;
    logic [2:0] state_o;
    logic [3:0] wdt_trips_o;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          m_trips = 0;
    logic        mon_en = 1'b0;
    logic [9:0]  mon_prev;
    logic [9:0]  mon_cur;
    exp_t        mon_e;

    pulpino_boot_sequencer #(
        .DEBOUNCE_CYC  (DB),
        .SYS_HOLD_CYC  (SH),
        .CORE_HOLD_CYC (CH),
        .FETCH_DLY_CYC (FD),
        .WDT_CYC       (WD)
    ) dut (
        .clk50        (clk50),
        .reset_n      (reset_n),
        .btn_n        (btn_n),
        .wdt_en       (wdt_en),
        .core_hb      (core_hb),
        .core_eoc     (core_eoc),
        .sys_rst_n    (sys_rst_n),
        .core_rst_n   (core_rst_n),
        .fetch_enable (fetch_enable),
        .state_o      (state_o),
        .wdt_trips_o  (wdt_trips_o)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) cyc <= cyc + 1;

    // Expected {sys_rst_n, core_rst_n, fetch_enable} for each phase.
    function automatic logic [2:0] pins_of(input int st);
        case (st)
            ST_CORE:  pins_of = 3'b100;
            ST_FETCH: pins_of = 3'b110;
            ST_RUN:   pins_of = 3'b111;
            ST_HALT:  pins_of = 3'b110;
            default:  pins_of = 3'b000;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic push(input int st, input int trips, input int unsigned at);
        exp_t e;
        e.st    = st;
        e.trips = trips;
        e.cyc   = at;
        exp_q.push_back(e);
    endtask

    // Stages 0..3 = SYS_HOLD, CORE_HOLD, FETCH_DLY, RUN, counted from SYS_HOLD entry.
    task automatic push_seq(input int unsigned start, input int first, input int last);
        int unsigned off[4];
        int          st[4];
        off[0] = 0;       st[0] = ST_SYS;
        off[1] = SH;      st[1] = ST_CORE;
        off[2] = SH + CH; st[2] = ST_FETCH;
        off[3] = SH + CH + FD; st[3] = ST_RUN;
        for (int i = first; i <= last; i++) push(st[i], m_trips, start + off[i]);
    endtask

    task automatic wait_cyc(input int unsigned n);
        while (cyc < n) @(negedge clk50);
    endtask

    task automatic btn_low(input int unsigned len);
        btn_n = 1'b0;
        repeat (len) @(negedge clk50);
        btn_n = 1'b1;
    endtask

    // Monitor: every change of the output vector must match the next predicted event.
    always @(negedge clk50) begin
        if (mon_en) begin
            mon_cur = {state_o, sys_rst_n, core_rst_n, fetch_enable, wdt_trips_o};
            if (mon_cur !== mon_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got state=%0d pins=%b trips=%0d at cycle %0d, expected no change",
                             state_o, {sys_rst_n, core_rst_n, fetch_enable}, wdt_trips_o, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_state", int'(state_o), mon_e.st);
                    chk("event_pins", int'({sys_rst_n, core_rst_n, fetch_enable}), int'(pins_of(mon_e.st)));
                    chk("event_trips", int'(wdt_trips_o), mon_e.trips);
                    chk("event_cycle", int'(cyc), int'(mon_e.cyc));
                end
            end
            mon_prev = mon_cur;
        end
    end

    initial begin
        int unsigned r;
        int unsigned t;
        int unsigned h;
        int unsigned s;
        int unsigned c;
        int unsigned tl;
        int          n_trips;

        reset_n  = 1'b0;
        btn_n    = 1'b1;
        wdt_en   = 1'b0;
        core_hb  = 1'b0;
        core_eoc = 1'b0;

        // Power-on: reset for two edges, check the reset state, then release.
        wait_cyc(2);
        chk("reset_state", int'(state_o), ST_IDLE);
        chk("reset_pins", int'({sys_rst_n, core_rst_n, fetch_enable}), 0);
        chk("reset_trips", int'(wdt_trips_o), 0);
        mon_prev = {state_o, sys_rst_n, core_rst_n, fetch_enable, wdt_trips_o};
        mon_en   = 1'b1;
        reset_n  = 1'b1;
        push_seq(cyc + 1, 0, 3);
        r = cyc + 1 + SH + CH + FD;

        // End of computation -> HALT; then a press replays the sequence, and a second press
        // during SYS_HOLD restarts its count.
        wait_cyc(r + 5);
        core_eoc = 1'b1;
        push(ST_HALT, m_trips, r + 6);
        wait_cyc(r + 6);
        core_eoc = 1'b0;
        h = r + 10;
        wait_cyc(h);
        s = h + PRESS_LAT;
        push(ST_SYS, m_trips, s);
        btn_low(6);
        c = h + 14;
        wait_cyc(c);
        s = c + PRESS_LAT;
        push_seq(s, 1, 3);
        btn_low(6);
        r = s + SH + CH + FD;

        // Short glitch in RUN is ignored.
        wait_cyc(r + 5);
        btn_low(3);
        wait_cyc(r + 40);
        chk("glitch_state", int'(state_o), ST_RUN);
        chk("glitch_pins", int'({sys_rst_n, core_rst_n, fetch_enable}), 7);

        // Watchdog enabled with a static heartbeat; the count was frozen at 0 while disabled.
        wdt_en  = 1'b1;
        n_trips = 1;
        m_trips = 1;
        t = r + 40 + WD;
        push(ST_TRIP, m_trips, t);
        push_seq(t + 1, 0, 3);
        r = t + 1 + SH + CH + FD;

        // Disabling the watchdog freezes the count without clearing it.
        wait_cyc(r + 10);
        wdt_en = 1'b0;
        wait_cyc(r + 40);
        wdt_en  = 1'b1;
        n_trips = 2;
        m_trips = 2;
        t = r + 40 + (WD - 10);
        push(ST_TRIP, m_trips, t);
        push_seq(t + 1, 0, 3);
        r = t + 1 + SH + CH + FD;

        // A heartbeat edge landing on the terminal count wins; then regular heartbeats keep it alive.
        wait_cyc(r + WD - HB_LAT);
        core_hb = ~core_hb;
        tl = 0;
        for (int i = 0; i < 25; i++) begin
            tl = r + 49 + 20 * i;
            wait_cyc(tl);
            core_hb = ~core_hb;
        end
        n_trips = 3;
        m_trips = 3;
        t = tl + HB_LAT + WD;
        push(ST_TRIP, m_trips, t);
        push_seq(t + 1, 0, 3);
        r = t + 1 + SH + CH + FD;

        // Repeated trips saturate the counter at 15; the last sequence is cut by reset in CORE_HOLD.
        while (n_trips < 16) begin
            t = r + WD;
            n_trips++;
            m_trips = (n_trips > 15) ? 15 : n_trips;
            push(ST_TRIP, m_trips, t);
            if (n_trips < 16) begin
                push_seq(t + 1, 0, 3);
                r = t + 1 + SH + CH + FD;
            end else begin
                push_seq(t + 1, 0, 1);
            end
        end
        wait_cyc(t + 1 + SH + 4);
        reset_n = 1'b0;
        m_trips = 0;
        push(ST_IDLE, 0, cyc + 1);
        wait_cyc(cyc + 2);
        reset_n = 1'b1;
        push_seq(cyc + 1, 0, 3);
        r = cyc + 1 + SH + CH + FD;

        // A press and the watchdog terminal count in the same cycle: the press wins.
        c = r + WD - PRESS_LAT;
        wait_cyc(c);
        push(ST_SYS, m_trips, r + WD);
        push_seq(r + WD, 1, 3);
        btn_low(6);
        wait_cyc(r + WD + 2);
        wdt_en = 1'b0;
        r = r + WD + SH + CH + FD;
        wait_cyc(r + 20);

        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
